// File: rtl/psum_collector_pkg.sv
// Shared accelerator types and sizes for the partial-sum collector.
// Holds array dimensions, index widths and the collector state enum.
package accelerator_pkg;

    localparam int ARRAY_ROWS = 8;
    localparam int ARRAY_COLS = 8;
    localparam int PSUM_W     = 18;

    localparam int ROW_W = $clog2(ARRAY_ROWS);
    localparam int COL_W = $clog2(ARRAY_COLS);
    localparam int CNT_W = $clog2(ARRAY_ROWS + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } collector_state_t;

endpackage

// File: rtl/psum_collector_if.sv
// Result stream from the collector to the write-back stage.
// Ports: out_valid/out_ready handshake, out_data element, out_row/out_col index.
interface psum_collector_if #(
    parameter int DATA_W = accelerator_pkg::PSUM_W,
    parameter int ROW_W  = accelerator_pkg::ROW_W,
    parameter int COL_W  = accelerator_pkg::COL_W
);

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_col,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col,
        output out_ready
    );

endinterface

// File: rtl/psum_collector_col_buffer.sv
// One array column of the result buffer: ROWS-deep write-indexed store.
// Ports: clk, rst, clr (restart count), wr_en/wr_data (strobe + sum),
//   rd_idx/rd_data (row read), count (rows captured), ovf (strobe when full).
// With PSUM_COLLECTOR_RELU_EN defined, negative sums are captured as 0.
module psum_col_buffer #(
    parameter int ROWS   = accelerator_pkg::ARRAY_ROWS,
    parameter int PSUM_W = accelerator_pkg::PSUM_W,
    parameter int IDX_W  = $clog2(ROWS),
    parameter int CNT_W  = $clog2(ROWS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [PSUM_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [PSUM_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    logic [PSUM_W-1:0] mem [ROWS];
    logic              full;
    logic              wr_ok;
    logic [PSUM_W-1:0] wr_val;

    assign full  = (count == CNT_W'(ROWS));
    assign wr_ok = wr_en && !full;
    assign ovf   = wr_en && full;

`ifdef PSUM_COLLECTOR_RELU_EN
    assign wr_val = wr_data[PSUM_W-1] ? '0 : wr_data;
`else
    assign wr_val = wr_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wr_ok) begin
            count <= count + CNT_W'(1);
        end
    end

    // Storage needs no reset: an entry is only read once count passes it.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[count[IDX_W-1:0]] <= wr_val;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/psum_collector.sv
// De-skews per-column partial sums into a tile buffer and drains row-major.
// Ports: clk, rst, tile_start, col_valid/col_psum in; out_if stream (master);
//   tile_done pulse, busy, sticky err. Option: PSUM_COLLECTOR_RELU_EN.
module psum_collector #(
    parameter int ROWS   = accelerator_pkg::ARRAY_ROWS,
    parameter int COLS   = accelerator_pkg::ARRAY_COLS,
    parameter int PSUM_W = accelerator_pkg::PSUM_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tile_start,
    input  logic [COLS-1:0]        col_valid,
    input  logic [COLS*PSUM_W-1:0] col_psum,
    psum_collector_if.master       out_if,
    output logic                   tile_done,
    output logic                   busy,
    output logic                   err
);

    import accelerator_pkg::*;

    localparam int RIDX_W = $clog2(ROWS);
    localparam int CIDX_W = $clog2(COLS);
    localparam int WCNT_W = $clog2(ROWS + 1);

    collector_state_t state_q;
    collector_state_t state_d;

    logic [WCNT_W-1:0] wcnt    [COLS];
    logic [PSUM_W-1:0] rd_data [COLS];
    logic [COLS-1:0]   ovf;

    logic [RIDX_W-1:0] rrow;
    logic [CIDX_W-1:0] rcol;
    logic [WCNT_W-1:0] min_cnt;

    logic accepting;
    logic start;
    logic all_full;
    logic row_ready;
    logic out_valid;
    logic xfer;
    logic last_xfer;
    logic stray_wr;
    logic start_err;

    assign accepting = (state_q == COLLECT) || (state_q == DRAIN);
    assign start     = (state_q == IDLE) && tile_start;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        psum_col_buffer #(
            .ROWS   (ROWS),
            .PSUM_W (PSUM_W)
        ) u_col (
            .clk     (clk),
            .rst     (rst),
            .clr     (start),
            .wr_en   (col_valid[c] && accepting),
            .wr_data (col_psum[c*PSUM_W +: PSUM_W]),
            .rd_idx  (rrow),
            .rd_data (rd_data[c]),
            .count   (wcnt[c]),
            .ovf     (ovf[c])
        );
    end

    // The slowest column bounds how many rows are complete.
    always_comb begin
        min_cnt = WCNT_W'(ROWS);
        for (int c = 0; c < COLS; c++) begin
            if (wcnt[c] < min_cnt) begin
                min_cnt = wcnt[c];
            end
        end
    end

    assign all_full  = (min_cnt == WCNT_W'(ROWS));
    assign row_ready = (min_cnt > WCNT_W'(rrow));

    assign out_valid = accepting && row_ready;
    assign xfer      = out_valid && out_if.out_ready;
    assign last_xfer = xfer
                    && (rrow == RIDX_W'(ROWS - 1))
                    && (rcol == CIDX_W'(COLS - 1));

    // Buffer entries are write-once per tile, so the selected word holds
    // steady for as long as the pointer is stalled.
    assign out_if.out_valid = out_valid;
    assign out_if.out_data  = rd_data[rcol];
    assign out_if.out_row   = rrow;
    assign out_if.out_col   = rcol;

    assign stray_wr  = (|col_valid)
                    && ((state_q == IDLE) || (state_q == DONE));
    assign start_err = tile_start && (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (tile_start) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (last_xfer) begin
                    state_d = DONE;
                end else if (all_full) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_xfer) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrow <= '0;
            rcol <= '0;
        end else if (start) begin
            rrow <= '0;
            rcol <= '0;
        end else if (xfer) begin
            if (rcol == CIDX_W'(COLS - 1)) begin
                rcol <= '0;
                rrow <= rrow + RIDX_W'(1);
            end else begin
                rcol <= rcol + CIDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (stray_wr || start_err || (|ovf)) begin
            err <= 1'b1;
        end
    end

    assign tile_done = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: table of tile runs plus
// hand sequences for mid-tile reset and idle-strobe errors.
module tb_psum_collector;

    localparam int R = 8;
    localparam int C = 8;
    localparam int W = 18;

    logic           clk = 1'b0;
    logic           rst;
    logic           tile_start;
    logic [C-1:0]   col_valid;
    logic [C*W-1:0] col_psum;
    logic           tile_done;
    logic           busy;
    logic           err;

    psum_collector_if #(.DATA_W(W), .ROW_W(3), .COL_W(3)) out_if ();

    psum_collector dut (
        .clk        (clk),
        .rst        (rst),
        .tile_start (tile_start),
        .col_valid  (col_valid),
        .col_psum   (col_psum),
        .out_if     (out_if.master),
        .tile_done  (tile_done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         mode;
        logic [3:0] rdy;
        bit         ovf3;
        int         exp_first;
        int         exp_xfers;
        int         exp_done;
        logic       exp_err;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] elem(input int mode, input int r,
                                          input int c);
        if (mode == 1) return W'(-5);
        return W'(100 * r + c);
    endfunction

    function automatic logic [W-1:0] exp_elem(input int mode, input int r,
                                              input int c);
`ifdef PSUM_COLLECTOR_RELU_EN
        if (mode == 1) return '0;
`endif
        return elem(mode, r, c);
    endfunction

    task automatic run_tile(input vec_t v, input string tag);
        int       n;
        int       first;
        int       done_cnt;
        int       done_cyc;
        int       last_cyc;
        bit       stalled;
        bit       fin;
        logic [W-1:0] hd;
        logic [2:0]   hr;
        logic [2:0]   hc;
        n = 0; first = -1; done_cnt = 0; done_cyc = -1; last_cyc = -1;
        stalled = 0; fin = 0; hd = '0; hr = '0; hc = '0;
        check({tag, " idle busy"}, busy, 0);
        tile_start = 1'b1;
        tick;
        tile_start = 1'b0;
        check({tag, " busy after start"}, busy, 1);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            col_valid = '0;
            col_psum  = '0;
            for (int c = 0; c < C; c++) begin
                int r;
                r = cyc - c;
                if (r >= 0 && r < R) begin
                    col_valid[c] = 1'b1;
                    col_psum[c*W +: W] = elem(v.mode, r, c);
                end
            end
            if (v.ovf3 && cyc == 11) begin
                col_valid[3] = 1'b1;
                col_psum[3*W +: W] = W'(999);
            end
            out_if.out_ready = v.rdy[cyc % 4];
            #4;
            if (out_if.out_valid && first < 0) first = cyc;
            if (stalled) begin
                check({tag, " stall hold"},
                      {out_if.out_valid, out_if.out_row, out_if.out_col,
                       out_if.out_data},
                      {1'b1, hr, hc, hd});
            end
            stalled = 0;
            if (out_if.out_valid) begin
                if (out_if.out_ready) begin
                    check({tag, " element"},
                          {out_if.out_row, out_if.out_col, out_if.out_data},
                          {3'(n / C), 3'(n % C),
                           exp_elem(v.mode, n / C, n % C)});
                    n++;
                    if (n == R * C) last_cyc = cyc;
                end else begin
                    stalled = 1;
                    hd = out_if.out_data;
                    hr = out_if.out_row;
                    hc = out_if.out_col;
                end
            end
            if (tile_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                fin = 1;
            end
            tick;
        end
        col_valid = '0;
        out_if.out_ready = 1'b0;
        check({tag, " first valid cycle"}, first, v.exp_first);
        check({tag, " transfers"}, n, v.exp_xfers);
        check({tag, " tile_done count"}, done_cnt, v.exp_done);
        check({tag, " tile_done timing"}, done_cyc, last_cyc + 1);
        check({tag, " err"}, err, v.exp_err);
    endtask

    initial begin
        vecs[0] = '{mode: 0, rdy: 4'b1111, ovf3: 0, exp_first: 8,
                    exp_xfers: 64, exp_done: 1, exp_err: 1'b0};
        vecs[1] = '{mode: 0, rdy: 4'b1001, ovf3: 0, exp_first: 8,
                    exp_xfers: 64, exp_done: 1, exp_err: 1'b0};
        vecs[2] = '{mode: 1, rdy: 4'b1111, ovf3: 0, exp_first: 8,
                    exp_xfers: 64, exp_done: 1, exp_err: 1'b0};
        vecs[3] = '{mode: 0, rdy: 4'b1111, ovf3: 1, exp_first: 8,
                    exp_xfers: 64, exp_done: 1, exp_err: 1'b1};

        rst = 1'b1;
        tile_start = 1'b0;
        col_valid = '0;
        col_psum = '0;
        out_if.out_ready = 1'b0;
        tick;
        tick;
        check("reset outputs",
              {out_if.out_valid, tile_done, busy, err,
               out_if.out_row, out_if.out_col},
              '0);
        rst = 1'b0;
        tick;

        // Consecutive runs start in the cycle right after tile_done.
        for (int i = 0; i < 4; i++) begin
            run_tile(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset after 20 writes, with rows 0-1 complete but not drained.
        tile_start = 1'b1;
        tick;
        tile_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            col_valid = (k < 2) ? 8'hFF : 8'h0F;
            for (int c = 0; c < C; c++) col_psum[c*W +: W] = elem(0, k, c);
            tick;
        end
        col_valid = '0;
        #3;
        check("mid-tile valid before reset", out_if.out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid-tile reset outputs",
              {out_if.out_valid, busy, tile_done, err}, '0);
        tick;
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 10; k++) begin
                #3;
                if (out_if.out_valid || tile_done || busy) seen++;
                tick;
            end
            check("quiet after reset", seen, 0);
        end
        run_tile(vecs[0], "post-reset");

        // A strobe while idle is flagged.
        check("err clear before idle strobe", err, 0);
        col_valid = 8'h01;
        tick;
        col_valid = '0;
        check("idle strobe err", err, 1);
        check("idle strobe no busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Sits directly downstream of the pre-load/compute unit and consumes its per-column final partial sums (systolic sum + compensation sum).
- Those sums leave the 8x8 array skewed: column c emits row k one cycle after column c-1.
- This block de-skews them into a ROWS x COLS result buffer and drains it in row-major order over a valid/ready stream to the write-back stage.
- It signals tile completion and flags protocol violations.

Parameters:
- ROWS, 8, result rows per tile.
- COLS, 8, array columns.
- PSUM_W, 18, signed partial-sum width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- tile_start  in  1  one-cycle pulse; arms collection of a new tile.
- col_valid  in  COLS  per-column sample strobe.
- col_psum  in  COLS*PSUM_W  packed signed sums; column c occupies bits [c*PSUM_W +: PSUM_W].
- out_valid  out  1  output element valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  PSUM_W  element value.
- out_row  out  3  row index of out_data, $clog2(ROWS) bits.
- out_col  out  3  column index of out_data, $clog2(COLS) bits.
- tile_done  out  1  one-cycle pulse after the last element is accepted.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, buffer contents don't-care.
- States and transitions:
  - IDLE -> COLLECT on tile_start.
  - COLLECT -> DRAIN when every column count reaches ROWS.
  - DRAIN -> DONE when element (ROWS-1, COLS-1) is accepted.
  - DONE -> IDLE unconditionally after one cycle; tile_done=1 only in DONE.
- Collect:
  - Per-column count wcnt[c] (0..ROWS).
  - col_valid[c] in COLLECT with wcnt[c]<ROWS writes buf[wcnt[c]][c]=col_psum[c] and increments wcnt[c].
  - Columns are independent; any skew, including simultaneous strobes, is legal.
- Row ready: row k is ready when min over c of wcnt[c] > k.
- Drain (overlaps COLLECT):
  - Read pointer (rrow, rcol) starts at (0,0).
  - out_valid=1 when state is COLLECT/DRAIN and row rrow is ready.
  - out_data/out_row/out_col are registered and hold stable while out_valid && !out_ready.
  - On a transfer, rcol increments; at COLS-1 it wraps to 0 and rrow increments.
- Latency: first element has out_valid the cycle after the write of buf[0][COLS-1]; steady throughput is 1 element/cycle.
- No input back-pressure: the buffer holds a full tile, so writes never stall.
- Error conditions, each setting err=1 and ignoring the offending event:
  - col_valid[c] while wcnt[c]==ROWS.
  - Any col_valid in IDLE or DONE.
  - tile_start while busy.
- err clears only on rst.
- Simultaneous events:
  - A write completing row k in the same cycle that row k-1's last element drains: both take effect; out_valid for row k follows next cycle.
  - tile_start in DONE is an error and is ignored; IDLE is entered normally.
- Reset mid-tile: immediate return to IDLE, counters cleared, partial data discarded, no tile_done.
- Arithmetic: values are stored unmodified (signed PSUM_W); no width change.

Optional Feature:
- Macro: PSUM_COLLECTOR_RELU_EN.
- Defined: a value with sign bit set is written into the buffer as 0 (ReLU at capture), and out_data is always non-negative.
- Undefined: values pass through signed and unmodified.
- Either way timing, indices and err behaviour are identical.

Decomposition:
- Shared package accelerator_pkg holds:
  - ARRAY_ROWS=8, ARRAY_COLS=8, PSUM_W=18.
  - State enum collector_state_t {IDLE, COLLECT, DRAIN, DONE}.
  - Index width localparams.
- One natural sub-module: psum_col_buffer, one instance per column.
  - Contents: ROWS-deep write-indexed register column, its wcnt, and its per-column overflow detect.
  - Ports: wr_en, wr_data, rd_idx, rd_data, count, ovf.
- The top level holds the FSM, the min-count/row-ready compare and the drain pointer.

Test Plan:
- Skewed tile: tile_start, then column c strobes in cycles c..c+7 with col_psum = 100*row + col. Required: 64 outputs in row-major order, data = 100*out_row + out_col; first out_valid at cycle 8; tile_done once after element (7,7).
- Back-pressure: same stimulus with out_ready toggling 1,0,0,1. Required: out_data/out_row/out_col stable during stalls, no loss or duplication, 64 transfers total.
- Negatives: col_psum = -5 for all elements. Required: out_data = -5 (0x3FFFB) without the macro; 0 with PSUM_COLLECTOR_RELU_EN.
- Overflow and protocol errors:
  - Column 3 given 9 strobes: err=1, the 9th is ignored, tile completes normally.
  - col_valid while IDLE: err=1.
- Reset mid-tile: rst asserted after 20 writes. Required: out_valid=0, busy=0, no tile_done; a following clean tile passes as in the skewed-tile scenario.
- Back-to-back tiles: tile_start in the cycle after tile_done. Required: accepted, err stays 0, second tile data correct.
